// File: rtl/adc_record_capture.sv
// Multi-channel ADC record capture: header + RECORD_LEN sample sets per record into a wide FIFO.
// Optional trailer word (drop count) is built when ADC_TRAILER_EN is defined.
module adc_record_capture #(
   parameter int NUM_CH     = 4,
   parameter int SAMPLE_W   = 14,
   parameter int RECORD_LEN = 1024,
   parameter int SIGNED     = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       cont_mode,
   input  logic                       adc_valid,
   input  logic [NUM_CH*SAMPLE_W-1:0] adc_data,
   input  logic                       fifo_full,
   input  logic                       fifo_rst_busy,
   output logic                       wr_en,
   output logic [NUM_CH*16-1:0]       dout,
   output logic                       busy,
   output logic [2:0]                 state,
   output logic                       overflow,
   output logic [15:0]                rec_cnt
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RSTWAIT = 3'd1,
      HEADER  = 3'd2,
      CAPTURE = 3'd3,
      TRAILER = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t               state_reg;
   logic                 wr_en_reg;
   logic [NUM_CH*16-1:0] dout_reg;
   logic                 busy_reg;
   logic                 overflow_reg;
   logic [15:0]          rec_cnt_reg;
   logic [15:0]          seq_reg;
   logic [15:0]          smp_cnt_reg;
   logic [15:0]          drop_cnt_reg;
   // High when start was low last cycle; cleared by reset so a start held through reset never fires.
   logic                 start_low_reg;

   logic [NUM_CH*16-1:0] fmt_data;
   logic [NUM_CH*16-1:0] header_word;
   logic                 start_edge;
   logic                 last_set;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
      logic [SAMPLE_W-1:0] sample;
      assign sample = adc_data[gi*SAMPLE_W +: SAMPLE_W];
      if (SIGNED != 0) begin : g_sext
         assign fmt_data[gi*16 +: 16] = 16'($signed(sample));
      end else begin : g_zext
         assign fmt_data[gi*16 +: 16] = 16'(sample);
      end
   end

   always_comb begin
      header_word        = '0;
      header_word[15:0]  = 16'hA55A;
      header_word[31:16] = seq_reg;
   end

`ifdef ADC_TRAILER_EN
   logic [NUM_CH*16-1:0] trailer_word;
   always_comb begin
      trailer_word        = '0;
      trailer_word[15:0]  = 16'h5AA5;
      trailer_word[31:16] = drop_cnt_reg;
   end
`endif

   assign start_edge = start & start_low_reg;
   assign last_set   = (smp_cnt_reg == 16'(RECORD_LEN - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         wr_en_reg     <= 1'b0;
         dout_reg      <= '0;
         busy_reg      <= 1'b0;
         overflow_reg  <= 1'b0;
         rec_cnt_reg   <= '0;
         seq_reg       <= '0;
         smp_cnt_reg   <= '0;
         drop_cnt_reg  <= '0;
         start_low_reg <= 1'b0;
      end else begin
         wr_en_reg     <= 1'b0;
         start_low_reg <= ~start;
         // A FIFO reset while a record is in flight discards the partial record.
         if (fifo_rst_busy && (state_reg == HEADER || state_reg == CAPTURE ||
                               state_reg == TRAILER)) begin
            state_reg    <= RSTWAIT;
            smp_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
         end else begin
            case (state_reg)
               IDLE: begin
                  smp_cnt_reg  <= '0;
                  drop_cnt_reg <= '0;
                  if (start_edge) begin
                     state_reg    <= RSTWAIT;
                     busy_reg     <= 1'b1;
                     overflow_reg <= 1'b0;
                  end
               end
               RSTWAIT: begin
                  if (!fifo_rst_busy) state_reg <= HEADER;
               end
               HEADER: begin
                  if (!fifo_full) begin
                     wr_en_reg <= 1'b1;
                     dout_reg  <= header_word;
                     state_reg <= CAPTURE;
                  end
               end
               CAPTURE: begin
                  if (adc_valid) begin
                     smp_cnt_reg <= smp_cnt_reg + 16'd1;
                     if (!fifo_full) begin
                        wr_en_reg <= 1'b1;
                        dout_reg  <= fmt_data;
                     end else begin
                        overflow_reg <= 1'b1;
                        if (drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
                     end
`ifdef ADC_TRAILER_EN
                     if (last_set) state_reg <= TRAILER;
`else
                     if (last_set) state_reg <= DONE;
`endif
                  end
               end
`ifdef ADC_TRAILER_EN
               TRAILER: begin
                  if (!fifo_full) begin
                     wr_en_reg <= 1'b1;
                     dout_reg  <= trailer_word;
                     state_reg <= DONE;
                  end
               end
`endif
               DONE: begin
                  rec_cnt_reg  <= rec_cnt_reg + 16'd1;
                  seq_reg      <= seq_reg + 16'd1;
                  smp_cnt_reg  <= '0;
                  drop_cnt_reg <= '0;
                  if (cont_mode && start) begin
                     state_reg <= HEADER;
                  end else begin
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                  end
               end
               default: begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign wr_en    = wr_en_reg;
   assign dout     = dout_reg;
   assign busy     = busy_reg;
   assign state    = state_reg;
   assign overflow = overflow_reg;
   assign rec_cnt  = rec_cnt_reg;

endmodule

// File: tb/tb_adc_record_capture.sv
// Directed bench for adc_record_capture (NUM_CH=4, SAMPLE_W=14, RECORD_LEN=8); a SIGNED=1 copy shares the inputs.
module tb_adc_record_capture;

`ifdef ADC_TRAILER_EN
   localparam int TR = 1;
`else
   localparam int TR = 0;
`endif
   localparam int RW = 9 + TR;

   logic        clk = 1'b0;
   logic        rst, start, cont_mode, adc_valid, fifo_full, fifo_rst_busy;
   logic [55:0] adc_data;
   logic        wr_en, busy, overflow, wr_en_s, busy_s, overflow_s;
   logic [63:0] dout, dout_s;
   logic [2:0]  state, state_s;
   logic [15:0] rec_cnt, rec_cnt_s;

   int checks = 0;
   int errors = 0;
   logic [63:0] q[$];
   logic [63:0] qs[$];

   always #5 clk = ~clk;

   adc_record_capture #(.NUM_CH(4), .SAMPLE_W(14), .RECORD_LEN(8), .SIGNED(0)) dut (
      .clk(clk), .rst(rst), .start(start), .cont_mode(cont_mode), .adc_valid(adc_valid),
      .adc_data(adc_data), .fifo_full(fifo_full), .fifo_rst_busy(fifo_rst_busy),
      .wr_en(wr_en), .dout(dout), .busy(busy), .state(state), .overflow(overflow),
      .rec_cnt(rec_cnt));

   adc_record_capture #(.NUM_CH(4), .SAMPLE_W(14), .RECORD_LEN(8), .SIGNED(1)) dut_s (
      .clk(clk), .rst(rst), .start(start), .cont_mode(cont_mode), .adc_valid(adc_valid),
      .adc_data(adc_data), .fifo_full(fifo_full), .fifo_rst_busy(fifo_rst_busy),
      .wr_en(wr_en_s), .dout(dout_s), .busy(busy_s), .state(state_s), .overflow(overflow_s),
      .rec_cnt(rec_cnt_s));

   always @(negedge clk) begin
      if (wr_en) q.push_back(dout);
      if (wr_en_s) qs.push_back(dout_s);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [55:0] set_data(int n);
      logic [55:0] d = '0;
      for (int k = 0; k < 4; k++) d[k*14 +: 14] = 14'(256*k + n);
      return d;
   endfunction

   function automatic logic [63:0] exp_set(int n);
      logic [63:0] d = '0;
      for (int k = 0; k < 4; k++) d[k*16 +: 16] = 16'(256*k + n);
      return d;
   endfunction

   function automatic logic [63:0] hdr(int s);
      return {16'h0000, 16'h0000, 16'(s), 16'hA55A};
   endfunction

   function automatic logic [63:0] trl(int d);
      return {16'h0000, 16'h0000, 16'(d), 16'h5AA5};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end else begin
         $display("ok   %s: %h", name, got);
      end
   endtask

   // Rising start edge, then RSTWAIT -> HEADER -> header written.
   task automatic arm(string name);
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      chk({name, "_rstwait"}, 64'(state), 64'd1);
      tick();
      chk({name, "_header_state"}, 64'(state), 64'd2);
      tick();
      chk({name, "_capture_state"}, 64'(state), 64'd3);
   endtask

   task automatic run_sets(int n0, int n1, int flo, int fhi);
      for (int n = n0; n <= n1; n++) begin
         adc_valid = 1'b1;
         adc_data  = set_data(n);
         fifo_full = (n >= flo && n <= fhi);
         tick();
      end
      adc_valid = 1'b0;
      fifo_full = 1'b0;
   endtask

   task automatic wait_idle(string name);
      for (int i = 0; i < 100 && busy; i++) tick();
      chk({name, "_idle_timeout"}, 64'(busy), 64'd0);
   endtask

   task automatic test_reset();
      repeat (3) tick();
      chk("reset_wr_en", 64'(wr_en), 64'd0);
      chk("reset_dout", dout, 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_state", 64'(state), 64'd0);
      chk("reset_overflow", 64'(overflow), 64'd0);
      chk("reset_rec_cnt", 64'(rec_cnt), 64'd0);
      rst = 1'b0;
      repeat (4) tick();
      chk("reset_start_held_no_trigger", 64'(state), 64'd0);
   endtask

   task automatic test_single();
      q.delete();
      arm("single");
      chk("single_header_wr", 64'(wr_en), 64'd1);
      run_sets(0, 3, 99, 99);
      start = 1'b0;
      run_sets(4, 7, 99, 99);
      wait_idle("single");
      chk("single_words", 64'(q.size()), 64'(RW));
      if (q.size() == RW) begin
         chk("single_hdr", q[0], hdr(0));
         for (int n = 0; n < 8; n++) chk($sformatf("single_set%0d", n), q[1+n], exp_set(n));
         if (TR != 0) chk("single_trailer", q[9], trl(0));
      end
      chk("single_rec_cnt", 64'(rec_cnt), 64'd1);
      chk("single_overflow", 64'(overflow), 64'd0);
      chk("single_state_idle", 64'(state), 64'd0);
   endtask

   task automatic test_cont();
      int  saw_rstwait = 0;
      int  done = 0;
      q.delete();
      cont_mode = 1'b1;
      arm("cont");
      adc_valid = 1'b1;
      adc_data  = set_data(8'h33);
      for (int i = 0; i < 400 && !done; i++) begin
         tick();
         if (state == 3'd1) saw_rstwait = 1;
         if (q.size() >= 2*RW + 1) start = 1'b0;
         if (!busy) done = 1;
      end
      adc_valid = 1'b0;
      cont_mode = 1'b0;
      chk("cont_finished", 64'(done), 64'd1);
      chk("cont_words", 64'(q.size()), 64'(3*RW));
      if (q.size() == 3*RW)
         for (int r = 0; r < 3; r++) chk($sformatf("cont_hdr%0d", r), q[r*RW], hdr(1 + r));
      chk("cont_no_rstwait", 64'(saw_rstwait), 64'd0);
      chk("cont_rec_cnt", 64'(rec_cnt), 64'd4);
      chk("cont_state_idle", 64'(state), 64'd0);
   endtask

   task automatic test_overflow();
      logic [63:0] exp[$];
      q.delete();
      arm("ovf");
      run_sets(0, 7, 3, 4);
      wait_idle("ovf");
      exp.push_back(hdr(4));
      for (int n = 0; n < 8; n++) if (n != 3 && n != 4) exp.push_back(exp_set(n));
      if (TR != 0) exp.push_back(trl(2));
      chk("ovf_words", 64'(q.size()), 64'(exp.size()));
      if (q.size() == exp.size())
         for (int i = 0; i < exp.size(); i++) chk($sformatf("ovf_word%0d", i), q[i], exp[i]);
      chk("ovf_flag", 64'(overflow), 64'd1);
      chk("ovf_rec_cnt", 64'(rec_cnt), 64'd5);
   endtask

   task automatic test_abort();
      q.delete();
      arm("abort");
      chk("abort_overflow_cleared", 64'(overflow), 64'd0);
      run_sets(0, 3, 99, 99);
      fifo_rst_busy = 1'b1;
      adc_valid     = 1'b1;
      adc_data      = set_data(4);
      tick();
      adc_valid = 1'b0;
      chk("abort_state_rstwait", 64'(state), 64'd1);
      chk("abort_wr_en_low", 64'(wr_en), 64'd0);
      repeat (4) tick();
      chk("abort_still_waiting", 64'(state), 64'd1);
      fifo_rst_busy = 1'b0;
      tick();
      chk("abort_header_state", 64'(state), 64'd2);
      tick();
      chk("abort_new_hdr_wr", 64'(wr_en), 64'd1);
      chk("abort_new_hdr_same_seq", dout, hdr(5));
      chk("abort_rec_cnt_unchanged", 64'(rec_cnt), 64'd5);
      run_sets(0, 7, 99, 99);
      wait_idle("abort");
      chk("abort_words", 64'(q.size()), 64'(14 + TR));
      chk("abort_rec_cnt", 64'(rec_cnt), 64'd6);
   endtask

   task automatic test_signed();
      q.delete();
      qs.delete();
      arm("signed");
      adc_valid = 1'b1;
      adc_data  = {14'h0000, 14'h3FFF, 14'h1FFF, 14'h2000};
      repeat (8) tick();
      adc_valid = 1'b0;
      wait_idle("signed");
      chk("signed_words", 64'(qs.size()), 64'(RW));
      if (qs.size() == RW && q.size() == RW) begin
         chk("signed_hdr", qs[0], hdr(6));
         chk("signed_lanes", qs[1], {16'h0000, 16'hFFFF, 16'h1FFF, 16'hE000});
         chk("unsigned_lanes", q[1], {16'h0000, 16'h3FFF, 16'h1FFF, 16'h2000});
      end
      chk("signed_rec_cnt", 64'(rec_cnt_s), 64'd7);
   endtask

   task automatic test_reset_mid();
      arm("rmid");
      run_sets(0, 2, 1, 1);
      chk("rmid_overflow_before", 64'(overflow), 64'd1);
      rst       = 1'b1;
      adc_valid = 1'b1;
      adc_data  = set_data(3);
      tick();
      adc_valid = 1'b0;
      chk("rmid_wr_en", 64'(wr_en), 64'd0);
      chk("rmid_state", 64'(state), 64'd0);
      chk("rmid_busy", 64'(busy), 64'd0);
      chk("rmid_overflow", 64'(overflow), 64'd0);
      chk("rmid_rec_cnt", 64'(rec_cnt), 64'd0);
      chk("rmid_dout", dout, 64'd0);
      rst = 1'b0;
      repeat (4) tick();
      chk("rmid_start_held_no_trigger", 64'(state), 64'd0);
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      chk("rmid_retrigger", 64'(state), 64'd1);
      tick();
      tick();
      chk("rmid_hdr_seq0", dout, hdr(0));
      run_sets(0, 7, 99, 99);
      wait_idle("rmid");
      chk("rmid_rec_cnt_after", 64'(rec_cnt), 64'd1);
   endtask

   initial begin
      rst           = 1'b1;
      start         = 1'b1;
      cont_mode     = 1'b0;
      adc_valid     = 1'b0;
      adc_data      = '0;
      fifo_full     = 1'b0;
      fifo_rst_busy = 1'b0;
      test_reset();
      test_single();
      test_cont();
      test_overflow();
      test_abort();
      test_signed();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
